// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO.
// One shift-add or restoring-divide step per cycle for WIDTH cycles.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       mult_func,
    output logic [WIDTH-1:0] c_mult,
    output logic             pause_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    localparam logic [3:0] F_READ_LO  = 4'd1;
    localparam logic [3:0] F_READ_HI  = 4'd2;
    localparam logic [3:0] F_WRITE_LO = 4'd3;
    localparam logic [3:0] F_WRITE_HI = 4'd4;
    localparam logic [3:0] F_MULTU    = 4'd5;
    localparam logic [3:0] F_MULT     = 4'd6;
    localparam logic [3:0] F_DIVU     = 4'd7;
    localparam logic [3:0] F_DIV      = 4'd8;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q_q, neg_q_d;
    logic                 neg_r_q, neg_r_d;

    logic                 f_start;
    logic                 f_signed;
    logic                 f_div;
    logic                 f_read;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_new;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   step_res;
    logic [2*WIDTH-1:0]   prod_neg;
    logic [WIDTH-1:0]     quo_fin;
    logic [WIDTH-1:0]     rem_fin;

    always_comb begin
        f_start  = (mult_func >= F_MULTU) && (mult_func <= F_DIV);
        f_signed = (mult_func == F_MULT) || (mult_func == F_DIV);
        f_div    = (mult_func == F_DIVU) || (mult_func == F_DIV);
        f_read   = (mult_func == F_READ_LO) || (mult_func == F_READ_HI);
        a_abs    = (f_signed && a_in[WIDTH-1]) ? -a_in : a_in;
        b_abs    = (f_signed && b_in[WIDTH-1]) ? -b_in : b_in;
    end

    // Step datapaths: prod holds {acc,multiplier} for mult, {rem,quotient} for div.
    always_comb begin
        sum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + (prod_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {sum, prod_q[WIDTH-1:1]};
        rem_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        rem_ge   = rem_sh >= {1'b0, opnd_q};
        rem_new  = rem_ge ? (rem_sh[WIDTH-1:0] - opnd_q)
                          : rem_sh[WIDTH-1:0];
        div_next = {rem_new, prod_q[WIDTH-2:0], rem_ge};
        step_res = is_div_q ? div_next : mul_next;
        prod_neg = -step_res;
        quo_fin  = neg_q_q ? -step_res[WIDTH-1:0]
                           : step_res[WIDTH-1:0];
        rem_fin  = neg_r_q ? -step_res[2*WIDTH-1:WIDTH]
                           : step_res[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        prod_d   = prod_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;

        if (f_start) begin
            state_d  = BUSY;
            count_d  = CNT_INIT;
            is_div_d = f_div;
            neg_q_d  = f_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            neg_r_d  = f_signed & a_in[WIDTH-1];
            prod_d   = {{WIDTH{1'b0}}, f_div ? a_abs : b_abs};
            opnd_d   = f_div ? b_abs : a_abs;
        end else if (mult_func == F_WRITE_LO ||
                     mult_func == F_WRITE_HI) begin
            state_d = IDLE;
            count_d = '0;
            if (mult_func == F_WRITE_LO) lo_d = a_in;
            else                         hi_d = a_in;
        end else if (state_q == BUSY) begin
            prod_d  = step_res;
            count_d = count_q - CNT_LAST;
            if (count_q == CNT_LAST) begin
                state_d = IDLE;
                if (is_div_q) begin
                    lo_d = quo_fin;
                    hi_d = rem_fin;
                end else if (neg_q_q) begin
                    {hi_d, lo_d} = prod_neg;
                end else begin
                    {hi_d, lo_d} = step_res;
                end
            end
        end
    end

    always_comb begin
        c_mult    = '0;
        pause_out = (state_q == BUSY) & f_read;
        unique case (1'b1)
            mult_func == F_READ_HI: c_mult = hi_q;
            mult_func == F_READ_LO: c_mult = lo_q;
            default:                c_mult = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            prod_q   <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            prod_q   <= prod_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
        end
    end

endmodule
